// File: rtl/ddr2_tgen_pkg.sv
// Shared definitions for the DDR2 traffic generator: FSM encoding,
// the address-derived data pattern, the LFSR tap mask and the error
// counter width.
package ddr2_tgen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_ACK   = 3'd2,
        ST_WR_DONE  = 3'd3,
        ST_RD_ISSUE = 3'd4,
        ST_RD_ACK   = 3'd5,
        ST_RD_DONE  = 3'd6,
        ST_FIN      = 3'd7
    } tgen_state_t;

    localparam int ERR_CNT_W = 16;

    // Fibonacci taps 64,63,61,60 (1-based) -> bits 63,62,60,59.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Upper half is the inverted zero-extended address, lower half the address.
    function automatic logic [63:0] addr_pattern(input logic [31:0] a);
        return {~a, a};
    endfunction

endpackage

// File: rtl/ddr2_tgen_lfsr.sv
// 64-bit Fibonacci LFSR with synchronous load (priority) and step.
// Pure datapath: always loaded before its value is consumed, so no reset.
import ddr2_tgen_pkg::*;

module ddr2_tgen_lfsr #(
    parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    output logic [63:0] q
);

    // Load the seed or shift in the XOR of the tapped bits.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[62:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/ddr2_traffic_gen.sv
// DDR2 user-port traffic generator: writes a pattern over an address
// window, reads it back, compares and reports pass/err_count/first_err_addr.
// Optional build macro TGEN_LFSR_DATA_EN selects LFSR data instead of the
// address-derived pattern.
import ddr2_tgen_pkg::*;

module ddr2_traffic_gen #(
    parameter int unsigned ADDR_W         = 26,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned START_ADDR     = 0,
    parameter int unsigned NUM_WORDS      = 256,
    parameter int unsigned ADDR_STEP      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [63:0] LFSR_SEED      = 64'h0123_4567_89AB_CDEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic                 timeout,
    output logic [ADDR_W-1:0]    c_addr,
    output logic [DATA_W-1:0]    c_data_in,
    output logic                 c_wr_req,
    output logic                 c_rd_req,
    input  logic [DATA_W-1:0]    c_data_out,
    input  logic                 c_rdy
);

    localparam logic [16:0]       NUM_W = 17'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);

    tgen_state_t          state;
    logic [16:0]          idx;
    logic [ADDR_W-1:0]    addr;
    logic [31:0]          tcnt;
    logic                 progress;
    logic                 in_wait;
    logic                 tmo;
    logic                 last_word;
    logic                 mis;
    logic [DATA_W-1:0]    pat_data;
    logic [ERR_CNT_W-1:0] err_next;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    // A wait state makes progress when the handshake condition it waits on holds.
    always_comb begin
        progress = 1'b0;
        case (state)
            ST_WR_ISSUE, ST_RD_ISSUE: progress = c_rdy;
            ST_WR_ACK,   ST_RD_ACK:   progress = !c_rdy;
            ST_WR_DONE,  ST_RD_DONE:  progress = c_rdy;
            default:                  progress = 1'b0;
        endcase
    end

    assign in_wait   = (state != ST_IDLE) && (state != ST_FIN);
    assign tmo       = (tcnt == 32'(TIMEOUT_CYCLES - 1));
    assign last_word = ((idx + 17'd1) == NUM_W);
    assign mis       = (c_data_out != pat_data);
    assign err_next  = sat_inc(err_count);

`ifdef TGEN_LFSR_DATA_EN
    logic [63:0] lfsr_q;
    logic        lfsr_load;
    logic        lfsr_step;

    // Reload at start and at the write->read turn so reads replay the write sequence.
    assign lfsr_load = ((state == ST_IDLE) && start) ||
                       ((state == ST_WR_DONE) && c_rdy && last_word);
    assign lfsr_step = ((state == ST_WR_DONE) || (state == ST_RD_DONE)) && c_rdy;

    ddr2_tgen_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .load (lfsr_load),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign pat_data = DATA_W'(lfsr_q);
`else
    logic lfsr_seed_unused;

    assign pat_data         = DATA_W'(addr_pattern(32'(addr)));
    // The seed only matters for the LFSR build.
    assign lfsr_seed_unused = ^LFSR_SEED;
`endif

    // Main sequencer: handshake FSM, per-state timeout, result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            c_addr         <= '0;
            c_data_in      <= '0;
            c_wr_req       <= 1'b0;
            c_rd_req       <= 1'b0;
            idx            <= '0;
            addr           <= '0;
            tcnt           <= '0;
        end else begin
            done     <= 1'b0;
            c_wr_req <= 1'b0;
            c_rd_req <= 1'b0;

            if (progress || !in_wait) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 32'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        timeout        <= 1'b0;
                        idx            <= '0;
                        addr           <= START;
                        state          <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE: begin
                    if (c_rdy) begin
                        c_wr_req  <= 1'b1;
                        c_addr    <= addr;
                        c_data_in <= pat_data;
                        state     <= ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (!c_rdy) state <= ST_WR_DONE;
                end
                ST_WR_DONE: begin
                    if (c_rdy) begin
                        if (last_word) begin
                            idx   <= '0;
                            addr  <= START;
                            state <= ST_RD_ISSUE;
                        end else begin
                            idx   <= idx + 17'd1;
                            addr  <= addr + STEP;
                            state <= ST_WR_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    if (c_rdy) begin
                        c_rd_req <= 1'b1;
                        c_addr   <= addr;
                        state    <= ST_RD_ACK;
                    end
                end
                ST_RD_ACK: begin
                    if (!c_rdy) state <= ST_RD_DONE;
                end
                ST_RD_DONE: begin
                    if (c_rdy) begin
                        if (mis) begin
                            err_count <= err_next;
                            if (err_count == '0) first_err_addr <= addr;
                        end
                        if (last_word) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !mis;
                            state <= ST_FIN;
                        end else begin
                            idx   <= idx + 17'd1;
                            addr  <= addr + STEP;
                            state <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A wait state that never sees its condition aborts the run.
            if (in_wait && !progress && tmo) begin
                timeout <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
                state   <= ST_FIN;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed bench for ddr2_traffic_gen: two instances (window at 0 with a
// short timeout, and a window straddling the top of the address space),
// each driven by a small ideal controller model with a memory array.
`timescale 1ns/1ps

module tb_ddr2_traffic_gen;

    localparam int AW = 26;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start   [2];
    logic          busy    [2];
    logic          done    [2];
    logic          pass    [2];
    logic [15:0]   err_cnt [2];
    logic [AW-1:0] fea     [2];
    logic          tmo     [2];
    logic [AW-1:0] caddr   [2];
    logic [DW-1:0] cdin    [2];
    logic          wreq    [2];
    logic          rreq    [2];
    logic [DW-1:0] rdata   [2];
    logic          rdy     [2];

    // controller model state
    logic          mrst    [2];
    logic          hang    [2];
    logic          corrupt [2];
    logic          hung    [2];
    logic          pend_rd [2];
    logic          both    [2];
    logic          viol    [2];
    int            mcnt    [2];
    int            wr_n    [2];
    int            rd_n    [2];
    logic [AW-1:0] raddr   [2];
    logic [DW-1:0] mem     [2][16];
    logic [AW-1:0] wr_log  [2][8];
    logic [AW-1:0] rd_log  [2][8];
    logic [DW-1:0] wd_log  [2][8];

    int n_assert;
    int n_fail;

    always #5 clk = ~clk;

    ddr2_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(0), .NUM_WORDS(4),
        .ADDR_STEP(1), .TIMEOUT_CYCLES(16), .LFSR_SEED(64'h0123_4567_89AB_CDEF)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err_cnt[0]), .first_err_addr(fea[0]),
        .timeout(tmo[0]), .c_addr(caddr[0]), .c_data_in(cdin[0]),
        .c_wr_req(wreq[0]), .c_rd_req(rreq[0]), .c_data_out(rdata[0]), .c_rdy(rdy[0])
    );

    ddr2_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(26'h3FFFFFE), .NUM_WORDS(4),
        .ADDR_STEP(1), .TIMEOUT_CYCLES(4096), .LFSR_SEED(64'h0123_4567_89AB_CDEF)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err_cnt[1]), .first_err_addr(fea[1]),
        .timeout(tmo[1]), .c_addr(caddr[1]), .c_data_in(cdin[1]),
        .c_wr_req(wreq[1]), .c_rd_req(rreq[1]), .c_data_out(rdata[1]), .c_rdy(rdy[1])
    );

    // Ideal controller: accept while ready, drop rdy next cycle, return after 5.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (mrst[m]) begin
                rdy[m]     <= 1'b1;
                rdata[m]   <= '0;
                mcnt[m]    <= 0;
                hung[m]    <= 1'b0;
                pend_rd[m] <= 1'b0;
                both[m]    <= 1'b0;
                viol[m]    <= 1'b0;
                wr_n[m]    <= 0;
                rd_n[m]    <= 0;
            end else begin
                if (wreq[m] && rreq[m]) both[m] <= 1'b1;
                if ((wreq[m] || rreq[m]) && !rdy[m]) viol[m] <= 1'b1;
                if ((wreq[m] || rreq[m]) && rdy[m]) begin
                    rdy[m]  <= 1'b0;
                    mcnt[m] <= 5;
                    if (wreq[m]) begin
                        mem[m][caddr[m][3:0]] <= cdin[m];
                        if (wr_n[m] < 8) begin
                            wr_log[m][wr_n[m]] <= caddr[m];
                            wd_log[m][wr_n[m]] <= cdin[m];
                        end
                        wr_n[m]    <= wr_n[m] + 1;
                        pend_rd[m] <= 1'b0;
                        if (hang[m]) hung[m] <= 1'b1;
                    end else begin
                        if (rd_n[m] < 8) rd_log[m][rd_n[m]] <= caddr[m];
                        rd_n[m]    <= rd_n[m] + 1;
                        raddr[m]   <= caddr[m];
                        pend_rd[m] <= 1'b1;
                    end
                end else if (!rdy[m] && !hung[m]) begin
                    if (mcnt[m] == 1) begin
                        rdy[m] <= 1'b1;
                        if (pend_rd[m])
                            rdata[m] <= mem[m][raddr[m][3:0]] ^
                                        {63'b0, (corrupt[m] && (raddr[m][3:0] == 4'd2))};
                    end
                    mcnt[m] <= mcnt[m] - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int s);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
    endtask

    task automatic mreset(input int s);
        mrst[s] = 1'b1;
        @(negedge clk);
        mrst[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done[s]) got = 1'b1;
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_ctl"}, {58'b0, busy[0], done[0], pass[0], tmo[0], wreq[0], rreq[0]}, 64'h0);
        chk({tag, "_err"}, {48'b0, err_cnt[0]}, 64'h0);
        chk({tag, "_fea"}, 64'(fea[0]), 64'h0);
        chk({tag, "_addr"}, 64'(caddr[0]), 64'h0);
        chk({tag, "_data"}, cdin[0], 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        int cyc;
        logic [63:0] exp_w0;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            start[m] = 1'b0; mrst[m] = 1'b1; hang[m] = 1'b0; corrupt[m] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_zero_a("reset");
        chk("reset_b_ctl", {62'b0, busy[1], done[1]}, 64'h0);
        rst = 1'b0;
        mrst[0] = 1'b0;
        mrst[1] = 1'b0;
        @(negedge clk);

        // 1: clean run over addresses 0..3
        pulse_start(0);
        chk("t1_busy", 64'(busy[0]), 64'h1);
        wait_done(0, 400, got);
        chk("t1_done", 64'(got), 64'h1);
        chk("t1_pass", 64'(pass[0]), 64'h1);
        chk("t1_err", 64'(err_cnt[0]), 64'h0);
        chk("t1_tmo", 64'(tmo[0]), 64'h0);
        chk("t1_busy_low", 64'(busy[0]), 64'h0);
        chk("t1_wr_n", 64'(wr_n[0]), 64'd4);
        chk("t1_rd_n", 64'(rd_n[0]), 64'd4);
        chk("t1_wr_addr3", 64'(wr_log[0][3]), 64'h3);
        chk("t1_rd_addr0", 64'(rd_log[0][0]), 64'h0);
        chk("t1_rd_addr3", 64'(rd_log[0][3]), 64'h3);
`ifdef TGEN_LFSR_DATA_EN
        exp_w0 = 64'h0123_4567_89AB_CDEF;
`else
        exp_w0 = 64'hFFFFFFFF_00000000;
        chk("t1_wdata3", wd_log[0][3], 64'hFFFFFFFC_00000003);
`endif
        chk("t1_wdata0", wd_log[0][0], exp_w0);
        chk("t1_proto", {62'b0, both[0], viol[0]}, 64'h0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done[0]), 64'h0);

        // 2: bit 0 of the read at address 2 corrupted
        corrupt[0] = 1'b1;
        mreset(0);
        pulse_start(0);
        wait_done(0, 400, got);
        chk("t2_done", 64'(got), 64'h1);
        chk("t2_err", 64'(err_cnt[0]), 64'h1);
        chk("t2_fea", 64'(fea[0]), 64'h2);
        chk("t2_pass", 64'(pass[0]), 64'h0);
        chk("t2_tmo", 64'(tmo[0]), 64'h0);
        corrupt[0] = 1'b0;

        // 3: controller never returns ready after the first write
        hang[0] = 1'b1;
        mreset(0);
        pulse_start(0);
        chk("t3_err_clr", 64'(err_cnt[0]), 64'h0);
        chk("t3_fea_clr", 64'(fea[0]), 64'h0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (!rdy[0]) got = 1'b1;
        end
        chk("t3_accept", 64'(got), 64'h1);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done[0]) got = 1'b1;
        end
        chk("t3_done", 64'(got), 64'h1);
        chk("t3_latency_le18", 64'(cyc <= 18), 64'h1);
        chk("t3_tmo", 64'(tmo[0]), 64'h1);
        chk("t3_pass", 64'(pass[0]), 64'h0);
        repeat (20) @(negedge clk);
        chk("t3_wr_once", 64'(wr_n[0]), 64'h1);
        chk("t3_no_repulse", {62'b0, viol[0], both[0]}, 64'h0);
        chk("t3_tmo_sticky", 64'(tmo[0]), 64'h1);
        hang[0] = 1'b0;
        mreset(0);

        // 4: window wrapping through the top of the address space
        pulse_start(1);
        wait_done(1, 400, got);
        chk("t4_done", 64'(got), 64'h1);
        chk("t4_pass", 64'(pass[1]), 64'h1);
        chk("t4_err", 64'(err_cnt[1]), 64'h0);
        chk("t4_wr0", 64'(wr_log[1][0]), 64'h3FFFFFE);
        chk("t4_wr1", 64'(wr_log[1][1]), 64'h3FFFFFF);
        chk("t4_wr2", 64'(wr_log[1][2]), 64'h0);
        chk("t4_wr3", 64'(wr_log[1][3]), 64'h1);
        chk("t4_rd1", 64'(rd_log[1][1]), 64'h3FFFFFF);
        chk("t4_rd2", 64'(rd_log[1][2]), 64'h0);
`ifndef TGEN_LFSR_DATA_EN
        chk("t4_wdata0", wd_log[1][0], 64'hFC000001_03FFFFFE);
`endif

        // 5: second start mid-run ignored, then reset during RD_ACK
        pulse_start(0);
        repeat (6) @(negedge clk);
        pulse_start(0);
        chk("t5_still_busy", 64'(busy[0]), 64'h1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (rreq[0]) got = 1'b1;
        end
        chk("t5_rd_seen", 64'(got), 64'h1);
        chk("t5_wr_n", 64'(wr_n[0]), 64'd4);
        chk("t5_rd_n", 64'(rd_n[0]), 64'd0);
        rst = 1'b1;
        #1;
        chk_zero_a("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        mreset(0);
        pulse_start(0);
        wait_done(0, 400, got);
        chk("t5_done", 64'(got), 64'h1);
        chk("t5_pass", 64'(pass[0]), 64'h1);
        chk("t5_err", 64'(err_cnt[0]), 64'h0);
        chk("t5_rd_n2", 64'(rd_n[0]), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
